// File: rtl/mbe_mult_arbiter_if.sv
// Requester-side and response-side handshake bundle for mbe_mult_arbiter.
// The master side is the set of requesters plus the response consumer.
// The slave side is the arbiter.
interface mbe_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [2*WIDTH-1:0]       resp_data;
  logic [ID_W-1:0]          resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/mbe_mult_arbiter.sv
// Round-robin arbiter that time-shares one multiplier between NUM_REQ
// requesters. One operation is in flight at a time: the winner's operands
// are registered onto mul_a/mul_b, the product is captured after MUL_LAT
// cycles and returned on the response channel tagged with the winner's id.
module mbe_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mbe_mult_arbiter_if.slave    bus,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_z,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // Keep the counter at least one bit wide so MUL_LAT=0 still elaborates.
  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SEND    = 2'd2
  } state_e;

  state_e               state_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic                 resp_valid_q;
  logic [2*WIDTH-1:0]   resp_data_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [15:0]          ops_done_q;
  logic [15:0]          ops_done_d;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]   req_ready_d;
  int                   idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // Accept is offered to the single winner, only while idle and out of reset.
  always_comb begin
    req_ready_d = '0;
    if (!rst && state_q == IDLE && grant_vld) begin
      req_ready_d[grant_idx] = 1'b1;
    end
  end

  assign ops_done_d = ops_done_q + 16'd1;

  // Control FSM with all datapath and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // grant_vld implies req_valid[g] and req_ready[g] on this edge.
          if (grant_vld) begin
            mul_a_q   <= bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
            mul_b_q   <= bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
            resp_id_q <= grant_idx;
            rr_ptr_q  <= grant_idx;
            cnt_q     <= CNT_W'(MUL_LAT);
            state_q   <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt_q == '0) begin
            resp_data_q  <= mul_z;
            resp_valid_q <= 1'b1;
            state_q      <= SEND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SEND: begin
          // Response fields hold until the consumer takes them.
          if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            ops_done_q   <= ops_done_d;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign busy           = (state_q != IDLE);
  assign ops_done       = ops_done_q;

endmodule

// File: tb/tb_mbe_mult_arbiter.sv
// Directed bench for mbe_mult_arbiter. dut0 uses a combinational multiplier
// (MUL_LAT=0); dut1 uses a three-stage multiplier (MUL_LAT=3).
module tb_mbe_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mul_a0, mul_b0, mul_a1, mul_b1;
  logic [63:0] mul_z0, mul_z1;
  logic [63:0] s1, s2, s3;
  logic        busy0, busy1;
  logic [15:0] ops0, ops1;

  int passed = 0;
  int total  = 0;

  mbe_mult_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) if0 ();
  mbe_mult_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) if1 ();

  mbe_mult_arbiter #(.NUM_REQ(4), .WIDTH(32), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_z(mul_z0),
    .busy(busy0), .ops_done(ops0)
  );

  mbe_mult_arbiter #(.NUM_REQ(4), .WIDTH(32), .MUL_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_z(mul_z1),
    .busy(busy1), .ops_done(ops1)
  );

  always #5 clk = ~clk;

  // Shared multiplier models: combinational for dut0, three registered stages for dut1.
  assign mul_z0 = {32'd0, mul_a0} * {32'd0, mul_b0};
  always @(posedge clk) begin
    s1 <= {32'd0, mul_a1} * {32'd0, mul_b1};
    s2 <= s1;
    s3 <= s2;
  end
  assign mul_z1 = s3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int          order [5];
    logic [63:0] prod  [4];
    logic [3:0]  oh;
    logic        saw, stable;
    int          lat;

    order = '{0, 1, 2, 3, 0};
    prod  = '{64'd30, 64'd44, 64'd60, 64'd78};

    rst = 1'b1;
    if0.req_valid = '0; if0.req_a = '0; if0.req_b = '0; if0.resp_ready = 1'b0;
    if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.resp_ready = 1'b0;
    tick();

    // Reset state; a pending request must not be accepted during reset.
    if0.req_valid    = 4'b0001;
    if0.req_a[31:0]  = 32'd7;
    if0.req_b[31:0]  = 32'd6;
    tick();
    check("rst_req_ready", 64'(if0.req_ready), 64'h0);
    check("rst_resp_valid", 64'(if0.resp_valid), 64'h0);
    check("rst_busy", 64'(busy0), 64'h0);
    check("rst_ops_done", 64'(ops0), 64'h0);
    check("rst_mul_a", 64'(mul_a0), 64'h0);
    check("rst_resp_data", if0.resp_data, 64'h0);

    // Single request: 7*6 from requester 0.
    rst = 1'b0;
    #1;
    check("single_grant", 64'(if0.req_ready), 64'h1);
    if0.resp_ready = 1'b1;
    tick();
    if0.req_valid = '0;
    check("single_busy", 64'(busy0), 64'h1);
    check("single_mul_a", 64'(mul_a0), 64'd7);
    check("single_mul_b", 64'(mul_b0), 64'd6);
    check("single_ready_compute", 64'(if0.req_ready), 64'h0);
    check("single_valid_early", 64'(if0.resp_valid), 64'h0);
    tick();
    check("single_valid", 64'(if0.resp_valid), 64'h1);
    check("single_data", if0.resp_data, 64'd42);
    check("single_id", 64'(if0.resp_id), 64'd0);
    tick();
    check("single_valid_low", 64'(if0.resp_valid), 64'h0);
    check("single_ops_done", 64'(ops0), 64'd1);
    check("single_idle", 64'(busy0), 64'h0);

    // Reset in the middle of an operation aborts it silently.
    if0.req_valid     = 4'b0010;
    if0.req_a[63:32]  = 32'd5;
    if0.req_b[63:32]  = 32'd5;
    #1;
    check("abort_grant1", 64'(if0.req_ready), 64'h2);
    tick();
    if0.req_valid = '0;
    check("abort_busy", 64'(busy0), 64'h1);
    rst = 1'b1;
    tick();
    tick();
    check("abort_resp_valid", 64'(if0.resp_valid), 64'h0);
    check("abort_busy_low", 64'(busy0), 64'h0);
    check("abort_ops_done", 64'(ops0), 64'h0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (if0.resp_valid) saw = 1'b1;
    end
    check("abort_no_resp", 64'(saw), 64'h0);

    // Round robin with every requester continuously valid.
    for (int i = 0; i < 4; i++) begin
      if0.req_a[i*32 +: 32] = 32'(10 + i);
      if0.req_b[i*32 +: 32] = 32'(3 + i);
    end
    if0.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << order[n];
      check($sformatf("rr_grant%0d", n), 64'(if0.req_ready), 64'(oh));
      tick();
      tick();
      check($sformatf("rr_id%0d", n), 64'(if0.resp_id), 64'(order[n]));
      check($sformatf("rr_data%0d", n), if0.resp_data, prod[order[n]]);
      tick();
    end
    check("rr_ops_done", 64'(ops0), 64'd5);

    // Backpressure: response held for 10 cycles while other requests wait.
    if0.req_valid     = 4'b0100;
    if0.req_a[95:64]  = 32'd9;
    if0.req_b[95:64]  = 32'd9;
    if0.resp_ready    = 1'b0;
    #1;
    check("bp_grant2", 64'(if0.req_ready), 64'h4);
    tick();
    if0.req_valid = 4'b1111;
    tick();
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (if0.resp_data !== 64'd81 || if0.resp_id !== 2'd2 || if0.req_ready !== 4'b0000
          || busy0 !== 1'b1 || if0.resp_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'h1);
    check("bp_data", if0.resp_data, 64'd81);
    check("bp_id", 64'(if0.resp_id), 64'd2);
    if0.resp_ready = 1'b1;
    tick();
    check("bp_valid_low", 64'(if0.resp_valid), 64'h0);
    check("bp_ops_done", 64'(ops0), 64'd6);
    check("bp_idle", 64'(busy0), 64'h0);
    check("bp_next_grant3", 64'(if0.req_ready), 64'h8);
    if0.req_valid = '0;
    tick();
    check("bp_stay_idle", 64'(busy0), 64'h0);

    // ops_done wraps from 16'hFFFF to 0.
    force dut0.ops_done_q = 16'hFFFF;
    tick();
    release dut0.ops_done_q;
    check("wrap_preload", 64'(ops0), 64'hFFFF);
    if0.req_valid    = 4'b0001;
    if0.req_a[31:0]  = 32'd2;
    if0.req_b[31:0]  = 32'd3;
    tick();
    if0.req_valid = '0;
    tick();
    check("wrap_data", if0.resp_data, 64'd6);
    tick();
    check("wrap_ops_done", 64'(ops0), 64'h0);

    // Latency with a three-cycle multiplier.
    if1.resp_ready    = 1'b1;
    if1.req_valid     = 4'b0001;
    if1.req_a[31:0]   = 32'hFFFF_FFFF;
    if1.req_b[31:0]   = 32'd2;
    #1;
    check("lat_grant0", 64'(if1.req_ready), 64'h1);
    tick();
    if1.req_valid = '0;
    lat = 0;
    while (!if1.resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("lat_cycles", 64'(lat), 64'd4);
    check("lat_data", if1.resp_data, 64'h1_FFFF_FFFE);
    check("lat_id", 64'(if1.resp_id), 64'd0);
    tick();
    check("lat_ops_done", 64'(ops1), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
